dpram_burst_reader: RTL
=======================

Name: dpram_burst_reader

Overview:
- Read-side initiator for one port of the team's single-clock dual-port RAM, which has registered read data and a 1-cycle read latency.
- Given a start address and a length, it issues sequential reads on the RAM port. It returns the data as a valid/ready stream with a last marker.
- Backpressure is absorbed by an internal 4-entry buffer, so the RAM is never stalled mid-read.
- It sits between a RAM port and a streaming consumer, such as a DMA, UART TX or framebuffer scan-out.

Parameters:
- DATA_WIDTH, 8, width of a RAM word and of the stream data.
- ADDR_WIDTH, 7, RAM address width; the RAM has 2^ADDR_WIDTH words.

Ports:
- clock  in  1  single clock for all logic; the RAM shares it.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a burst; sampled only while busy=0.
- start_addr  in  ADDR_WIDTH  first word address.
- length  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when a burst completes.
- mem_address  out  ADDR_WIDTH  drives address_x of the RAM port; the integrator ties that port's wren_x low.
- mem_rddata  in  DATA_WIDTH  rddata_x of the RAM port.
- out_valid  out  1  stream data valid.
- out_data  out  DATA_WIDTH  stream data.
- out_last  out  1  marks the final word of the burst.
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Reset values (async assert, sync release):
  - busy=0, done=0, out_valid=0, out_last=0, out_data=0, mem_address=0.
  - Buffer empty, counters zero, state IDLE.
  - Reset mid-burst abandons the burst; no done pulse is produced.
- States:
  - IDLE: start=1 latches addr<=start_addr, remaining_issue<=length, remaining_out<=length.
    - length=0: next state DONE.
    - length>0: next state RUN.
    - start while busy=1 is ignored.
  - RUN: issues reads under the rule below. When remaining_issue hits 0 with data still to deliver, next state DRAIN.
  - DRAIN: no issues. When the last word handshakes (out_valid & out_ready & out_last), next state DONE.
  - DONE: done=1 for one cycle, busy=0, next state IDLE. A start in the DONE cycle is accepted.
- busy is 1 in RUN and DRAIN only.
- Issue rule: a read issues in a cycle iff all of the following hold:
  - state is RUN;
  - remaining_issue > 0;
  - buffer occupancy + reads in flight <= 3. This is conservative: a pop in the same cycle is not credited.
- On issue:
  - mem_address = addr, registered;
  - then addr <= addr+1 modulo 2^ADDR_WIDTH, so the address wraps from top to 0;
  - remaining_issue decrements.
- Read pipeline:
  - Word issued in cycle n appears on mem_rddata in cycle n+1.
  - It is written into the buffer at the end of cycle n+1.
  - It is visible on out_data in cycle n+2.
- Latency: with start sampled at the end of cycle 0:
  - first read issues in cycle 1;
  - first out_valid is in cycle 3.
- Throughput: 1 word/cycle while out_ready=1.
- The buffer never overflows under the issue rule. Overflow is a verification assertion.
- Stream rules:
  - out_valid, once high, stays high with out_data and out_last stable until out_ready=1.
  - out_last=1 only on the word where remaining_out==1.
  - remaining_out decrements on each handshake.
- mem_address holds its last value when no read is issuing.
- No bypass is needed: this block never writes the RAM. Port-collision behaviour with writes on the other RAM port is the RAM's concern: old data is returned.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, RUN, DRAIN, DONE);
  - constant BUF_DEPTH=4;
  - the width rule that length is ADDR_WIDTH+1 bits.
- One natural sub-module: burst_skid_fifo.
  - Synchronous FIFO, depth 4, DATA_WIDTH+1 wide (data plus last).
  - Provides a count output and flop-based storage.

Test Plan:
- Reset, then start with start_addr=5, length=4, RAM[i]=i, out_ready=1.
  -> out_data 5,6,7,8 in cycles 3..6; out_last only on 8; done pulses in cycle 7; busy high in cycles 1..6.
- start_addr=126, length=4, ADDR_WIDTH=7.
  -> mem_address 126,127,0,1; data RAM[126],RAM[127],RAM[0],RAM[1].
- length=8, out_ready toggling 1,0,0,1,... plus random stalls.
  -> all 8 words in order with no loss or duplication; occupancy never exceeds 4; data stable while stalled.
- length=0.
  -> no out_valid; done pulses the cycle after start; start held high during busy causes no second burst.
- reset_n asserted mid-burst after 2 of 6 words.
  -> all outputs 0 immediately; no done; a fresh start afterwards behaves like the first scenario.
- length=128 (full RAM) with out_ready=1.
  -> 128 consecutive words with no gaps after the first; out_last on the 128th; exactly one done pulse.

Source files
------------

// File: rtl/dpram_burst_reader_pkg.sv
// Shared definitions for the dual-port RAM burst reader.
//   state_e    : controller states (idle, issuing reads, draining the buffer, completion pulse)
//   BUF_DEPTH  : entries in the output skid buffer
//   len_width  : width of the burst length, one bit wider than the address so that a
//                full-RAM burst (2^ADDR_WIDTH words) can be expressed
package dpram_burst_reader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    localparam int unsigned BUF_DEPTH = 4;

    function automatic int unsigned len_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/dpram_burst_reader_burst_skid_fifo.sv
// Flop-based synchronous FIFO that absorbs consumer backpressure behind the RAM read pipe.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   push, push_data: write one entry (must not be asserted while full)
//   pop            : remove the head entry (must not be asserted while empty)
//   head_data      : current head entry, all zeros after reset
//   empty, count   : occupancy status
module burst_skid_fifo
    import dpram_burst_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = BUF_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // Pointers wrap naturally; DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    always_comb begin
        head_data = mem_q[rd_ptr_q];
        empty     = (count_q == '0);
        count     = count_q;
    end

    // The issue credit rule upstream guarantees a free slot for every returning read.
    overflow_chk: assert property (@(posedge clock) disable iff (!reset_n)
        push |-> (count_q != FULL));

endmodule

// File: rtl/dpram_burst_reader.sv
// Read-side initiator for one port of a single-clock dual-port RAM with a 1-cycle registered
// read. Issues sequential reads from start_addr for length words and returns them as a
// valid/ready stream with a last marker.
// Ports:
//   clock, reset_n      : clock shared with the RAM, asynchronous active-low reset
//   start, start_addr,
//   length              : burst request, sampled only while busy is low
//   busy, done          : burst in progress / one-cycle completion pulse
//   mem_address         : RAM read address (write enable of that port is tied low outside)
//   mem_rddata          : RAM read data, valid one cycle after the address
//   out_valid, out_data,
//   out_last, out_ready : output stream
module dpram_burst_reader
    import dpram_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic [ADDR_WIDTH-1:0]               start_addr,
    input  logic [len_width(ADDR_WIDTH)-1:0]    length,
    output logic                                busy,
    output logic                                done,
    output logic [ADDR_WIDTH-1:0]               mem_address,
    input  logic [DATA_WIDTH-1:0]               mem_rddata,
    output logic                                out_valid,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic                                out_last,
    input  logic                                out_ready
);

    localparam int unsigned LEN_W = len_width(ADDR_WIDTH);
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    state_e             state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_W-1:0]   rem_issue_q;
    logic [LEN_W-1:0]   rem_out_q;
    logic               inflight_q;
    logic               inflight_last_q;
    logic               busy_q;
    logic               done_q;

    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   pending;
    logic               fifo_empty;
    logic [DATA_WIDTH:0] fifo_head;
    logic               issue;
    logic               pop;

    // A read may only issue if its word is guaranteed a buffer slot, counting the word
    // already in flight; a same-cycle pop is deliberately not credited.
    always_comb begin
        pending   = fifo_count + CNT_W'(inflight_q);
        issue     = (state_q == StRun) && (rem_issue_q != '0) &&
                    (pending <= CNT_W'(BUF_DEPTH - 1));
        out_valid = !fifo_empty;
        pop       = out_valid && out_ready;
        out_data  = fifo_head[DATA_WIDTH-1:0];
        out_last  = out_valid && fifo_head[DATA_WIDTH];
        busy      = busy_q;
        done      = done_q;
        // The address register is presented directly so the RAM samples it in the issue cycle.
        mem_address = addr_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            rem_issue_q     <= '0;
            rem_out_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue && (rem_issue_q == LEN_W'(1));
            done_q          <= 1'b0;
            if (issue) begin
                addr_q      <= addr_q + ADDR_WIDTH'(1);
                rem_issue_q <= rem_issue_q - LEN_W'(1);
            end
            if (pop) begin
                rem_out_q <= rem_out_q - LEN_W'(1);
            end
            unique case (state_q)
                // A start during the completion cycle is accepted like one in idle.
                StIdle, StDone: begin
                    if (start) begin
                        addr_q      <= start_addr;
                        rem_issue_q <= length;
                        rem_out_q   <= length;
                        if (length == '0) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StRun: begin
                    if (issue && (rem_issue_q == LEN_W'(1))) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (pop && (rem_out_q == LEN_W'(1))) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    burst_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight_q),
        .push_data ({inflight_last_q, mem_rddata}),
        .pop       (pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
